// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Widths, the hard-wired zero register and requester indices.
package rf_wb_arbiter_pkg;

  localparam int RF_DATA_W = 64;
  localparam int RF_ADDR_W = 5;

  localparam logic [RF_ADDR_W-1:0] ZERO_REG = '0;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant with a one-bit priority pointer.
// Pointer 0 favours the ALU requester on contention.
module rr_arb2
  import rf_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (valid_i == 2'b11): gnt_o = ptr_q ? 2'b10 : 2'b01;
      (valid_i == 2'b01): gnt_o = 2'b01;
      (valid_i == 2'b10): gnt_o = 2'b10;
      default:            gnt_o = 2'b00;
    endcase
  end

  // After a grant the other requester gets priority
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[REQ_ALU])  ptr_d = 1'b1;
    if (gnt_o[REQ_LOAD]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between ALU and load
// write-back, with read-port hazard flags and a stall counter.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W      = RF_DATA_W,
  parameter int ADDR_W      = RF_ADDR_W,
  parameter int CNT_W       = 16,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WN,
  output logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] RN1,
  input  logic [ADDR_W-1:0] RN2,
  output logic              hz1,
  output logic              hz2,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic [1:0]        gnt;
  logic              any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              stall;

  logic              we_q;
  logic [ADDR_W-1:0] wn_q;
  logic [DATA_W-1:0] wd_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i ({req1_valid, req0_valid}),
    .gnt_o   (gnt)
  );

  assign req0_ready = gnt[REQ_ALU];
  assign req1_ready = gnt[REQ_LOAD];
  assign any_gnt    = |gnt;
  assign sel_addr   = gnt[REQ_LOAD] ? req1_addr : req0_addr;
  assign sel_data   = gnt[REQ_LOAD] ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      wn_q <= '0;
      wd_q <= '0;
    end else begin
      // Zero-register writes are acknowledged but never reach the file
      we_q <= any_gnt && !(ZERO_REG_EN && sel_addr == ZR);
      if (any_gnt) begin
        wn_q <= sel_addr;
        wd_q <= sel_data;
      end
    end
  end

  assign RegWrite = we_q;
  assign WN       = wn_q;
  assign WD       = wd_q;

  // Granted or waiting, any valid requester is a pending write
  assign hz1 = !(ZERO_REG_EN && RN1 == ZR) &&
               ((we_q && RN1 == wn_q) ||
                (req0_valid && RN1 == req0_addr) ||
                (req1_valid && RN1 == req1_addr));
  assign hz2 = !(ZERO_REG_EN && RN2 == ZR) &&
               ((we_q && RN2 == wn_q) ||
                (req0_valid && RN2 == req0_addr) ||
                (req1_valid && RN2 == req1_addr));

  assign stall = (req0_valid && !gnt[REQ_ALU]) ||
                 (req1_valid && !gnt[REQ_LOAD]);

  always_comb begin
    cnt_d = cnt_q;
    if (stall_clr)                 cnt_d = '0;
    else if (stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;

endmodule
